// File: rtl/c4_move_driver_if.sv
// c4_move_driver_if: board/turn inputs and button-pulse outputs shared by the
// Connect-Four move driver (master) and the player-FSM side (slave).
interface c4_move_driver_if;
   logic        my_turn;       // player FSM is accepting moves
   logic [2:0]  cur_col;       // column currently selected by the player FSM
   logic [41:0] occupied;      // bit 7*row+col, row 0 = bottom
   logic        target_valid;  // a requested column is supplied
   logic [2:0]  target_col;    // requested column
   logic        left;          // button pulse: move selection left
   logic        right;         // button pulse: move selection right
   logic        put;           // button pulse: drop piece
   logic        busy;          // driver is not idle
   logic        move_done;     // one-cycle pulse as put rises
   logic        no_move;       // one-cycle pulse when the board has no legal column
   logic        error;         // one-cycle pulse when a step is never acknowledged

   modport master (
      input  my_turn, cur_col, occupied, target_valid, target_col,
      output left, right, put, busy, move_done, no_move, error
   );

   modport slave (
      output my_turn, cur_col, occupied, target_valid, target_col,
      input  left, right, put, busy, move_done, no_move, error
   );
endinterface

// File: rtl/c4_move_driver.sv
// c4_move_driver: automated Connect-Four opponent. On the player FSM's turn it
// picks a legal column, walks the FSM's cursor there one clean button pulse at
// a time, then presses put. All outputs are registered.
module c4_move_driver #(
   parameter int PULSE_LEN   = 2,   // cycles each button pulse is held high
   parameter int GAP_LEN     = 2,   // minimum low cycles after each pulse
   parameter int ACK_TIMEOUT = 16   // cycles to wait for cur_col to move
) (
   input logic              clk,
   input logic              rst,
   c4_move_driver_if.master bus
);

   localparam int PULSE_W = $clog2(PULSE_LEN + 1);
   localparam int GAP_W   = $clog2(GAP_LEN + 1);
   localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);

   localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(1);
   localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(PULSE_LEN);
   localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(GAP_LEN);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_CHOOSE    = 3'd1;
   localparam logic [2:0] ST_STEP      = 3'd2;
   localparam logic [2:0] ST_WAIT_COL  = 3'd3;
   localparam logic [2:0] ST_PUT       = 3'd4;
   localparam logic [2:0] ST_DONE_WAIT = 3'd5;

   logic [2:0]         state;
   logic [2:0]         tgt;          // column chosen for this turn
   logic [2:0]         col_at_step;  // cur_col captured when the current step began
   logic [PULSE_W-1:0] pulse_cnt;    // cycles the current pulse has been high
   logic [GAP_W-1:0]   gap_cnt;      // cycles low since the current pulse ended
   logic [TO_W-1:0]    to_cnt;       // cycles spent waiting for cur_col to move

   logic left_q, right_q, put_q;
   logic busy_q, move_done_q, no_move_q, error_q;

   logic [7:0] legal;       // bit c set when column c can take a piece; bit 7 never
   logic [2:0] lowest_col;
   logic       any_legal;
   logic [2:0] choice;
   logic       abort;
   logic       pulse_high;

   // Lower rows never affect legality; folding them keeps the bus port whole.
   logic occ_unused;
   assign occ_unused = ^bus.occupied[34:0];

   // Choose the requested column when legal, otherwise the lowest legal column.
   always_comb begin
      // NOTE: every always_comb output is assigned a default first, so no path can leave it holding a value (which would infer a latch).
      legal      = {1'b0, ~bus.occupied[41:35]};
      lowest_col = 3'd0;
      any_legal  = 1'b0;
      // Scan downward so the last hit is the lowest legal column.
      for (int c = 6; c >= 0; c--) begin
         if (legal[c]) begin
            lowest_col = 3'(c);
            any_legal  = 1'b1;
         end
      end
      choice = (bus.target_valid && legal[bus.target_col]) ? bus.target_col : lowest_col;
   end

   // my_turn dropping while a move is in progress cancels it outright.
   assign abort = !bus.my_turn &&
                  ((state == ST_CHOOSE) || (state == ST_STEP) ||
                   (state == ST_WAIT_COL) || (state == ST_PUT));

   assign pulse_high = left_q | right_q | put_q;

   // Turn sequencer: choose, step the cursor with pulse/gap timing, press put.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
      if (rst) begin
         state       <= ST_IDLE;
         tgt         <= '0;
         col_at_step <= '0;
         pulse_cnt   <= '0;
         gap_cnt     <= '0;
         to_cnt      <= '0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         put_q       <= 1'b0;
         busy_q      <= 1'b0;
         move_done_q <= 1'b0;
         no_move_q   <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         move_done_q <= 1'b0;
         no_move_q   <= 1'b0;
         error_q     <= 1'b0;
         if (abort) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
            put_q     <= 1'b0;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
            to_cnt    <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.my_turn) begin
                     state  <= ST_CHOOSE;
                     busy_q <= 1'b1;
                  end
               end

               ST_CHOOSE: begin
                  tgt <= choice;
                  if (!any_legal) begin
                     no_move_q <= 1'b1;
                     state     <= ST_DONE_WAIT;
                  end else if (bus.cur_col == choice) begin
                     state       <= ST_PUT;
                     put_q       <= 1'b1;
                     move_done_q <= 1'b1;
                     pulse_cnt   <= PULSE_ONE;
                     gap_cnt     <= '0;
                  end else begin
                     state       <= ST_STEP;
                     col_at_step <= bus.cur_col;
                     right_q     <= (choice > bus.cur_col);
                     left_q      <= (choice < bus.cur_col);
                     pulse_cnt   <= PULSE_ONE;
                     gap_cnt     <= '0;
                  end
               end

               // Both button phases share the same high-then-low timing.
               ST_STEP, ST_PUT: begin
                  if (pulse_cnt != PULSE_MAX) begin
                     pulse_cnt <= pulse_cnt + 1'b1;
                  end else if (pulse_high) begin
                     left_q  <= 1'b0;
                     right_q <= 1'b0;
                     put_q   <= 1'b0;
                     gap_cnt <= GAP_ONE;
                  end else if (gap_cnt != GAP_MAX) begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end else begin
                     state  <= (state == ST_STEP) ? ST_WAIT_COL : ST_DONE_WAIT;
                     to_cnt <= '0;
                  end
               end

               // The FSM moved if cur_col differs from the value captured at step start.
               ST_WAIT_COL: begin
                  if (bus.cur_col != col_at_step) begin
                     pulse_cnt <= PULSE_ONE;
                     gap_cnt   <= '0;
                     if (bus.cur_col == tgt) begin
                        state       <= ST_PUT;
                        put_q       <= 1'b1;
                        move_done_q <= 1'b1;
                     end else begin
                        state       <= ST_STEP;
                        col_at_step <= bus.cur_col;
                        right_q     <= (tgt > bus.cur_col);
                        left_q      <= (tgt < bus.cur_col);
                     end
                  end else if (to_cnt == TO_LAST) begin
                     error_q <= 1'b1;
                     state   <= ST_DONE_WAIT;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end

               ST_DONE_WAIT: begin
                  if (!bus.my_turn) begin
                     state  <= ST_IDLE;
                     busy_q <= 1'b0;
                  end
               end

               default: begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.left      = left_q;
   assign bus.right     = right_q;
   assign bus.put       = put_q;
   assign bus.busy      = busy_q;
   assign bus.move_done = move_done_q;
   assign bus.no_move   = no_move_q;
   assign bus.error     = error_q;

endmodule

// File: tb/tb_c4_move_driver.sv
// tb_c4_move_driver: directed and randomized turns against c4_move_driver with
// a small player-FSM model driving cur_col and a column-choice reference model.
module tb_c4_move_driver;
   localparam int PULSE_LEN   = 2;
   localparam int GAP_LEN     = 2;
   localparam int ACK_TIMEOUT = 16;
   localparam int WIN         = 60;   // cycles observed per turn

   logic       clk = 1'b0;
   logic       rst;
   int         checks   = 0;
   int         failures = 0;
   int         turn_id  = 0;
   logic       col_load = 1'b0;
   logic [2:0] col_load_val = 3'd0;
   logic       fsm_resp = 1'b1;
   logic       right_seen, left_seen;

   c4_move_driver_if bus ();

   c4_move_driver #(
      .PULSE_LEN  (PULSE_LEN),
      .GAP_LEN    (GAP_LEN),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial forever #5 clk = ~clk;

   // Player FSM model: moves cur_col one column on each registered rising edge.
   always @(posedge clk) begin
      right_seen <= bus.right;
      left_seen  <= bus.left;
      if (col_load)
         bus.cur_col <= col_load_val;
      else if (fsm_resp && bus.right && !right_seen && bus.cur_col < 3'd6)
         bus.cur_col <= bus.cur_col + 3'd1;
      else if (fsm_resp && bus.left && !left_seen && bus.cur_col > 3'd0)
         bus.cur_col <= bus.cur_col - 3'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s (turn %0d): observed=%0d expected=%0d", tag, turn_id, obs, exp);
      end
   endtask

   function automatic logic [41:0] col_full(input int c);
      logic [41:0] v;
      v = '0;
      for (int r = 0; r < 6; r++) v[7*r + c] = 1'b1;
      return v;
   endfunction

   // One full turn: reference expectations, stimulus, per-cycle observation, checks.
   task automatic run_turn(input logic [41:0] occ, input logic tv, input logic [2:0] tc,
                           input logic [2:0] c0, input logic resp);
      int   legal_cols[$];
      int   tgt, c0i, n;
      bit   any;
      int   n_right, n_left, n_put, n_done, n_nomove, n_err;
      int   put_k, done_k, nomove_k, err_k;
      int   overlap, width_viol, gap_viol, range_viol, busy_drop, width, low_run;
      bit   seen_pulse;
      logic any_btn, any_prev, r_prev, l_prev, p_prev;

      turn_id++;
      // Reference: legal columns are those with a free top-row cell.
      legal_cols.delete();
      for (int c = 0; c < 7; c++)
         if (!occ[7*5 + c]) legal_cols.push_back(c);
      any = (legal_cols.size() > 0);
      tgt = any ? legal_cols[0] : 0;
      if (tv)
         foreach (legal_cols[i])
            if (legal_cols[i] == int'(tc)) tgt = int'(tc);
      c0i = int'(c0);
      n   = (tgt > c0i) ? tgt - c0i : c0i - tgt;

      bus.occupied     = occ;
      bus.target_valid = tv;
      bus.target_col   = tc;
      col_load_val     = c0;
      col_load         = 1'b1;
      fsm_resp         = resp;
      @(negedge clk);
      col_load    = 1'b0;
      bus.my_turn = 1'b1;

      n_right = 0; n_left = 0; n_put = 0; n_done = 0; n_nomove = 0; n_err = 0;
      put_k = -1; done_k = -1; nomove_k = -1; err_k = -1;
      overlap = 0; width_viol = 0; gap_viol = 0; range_viol = 0; busy_drop = 0;
      width = 0; low_run = 0; seen_pulse = 0;
      any_prev = 1'b0; r_prev = 1'b0; l_prev = 1'b0; p_prev = 1'b0;

      for (int k = 1; k <= WIN; k++) begin
         @(negedge clk);
         // Scramble board and request once CHOOSE is over; they must be ignored.
         if (k == 3) begin
            bus.occupied     = {10'($urandom), $urandom};
            bus.target_valid = 1'($urandom);
            bus.target_col   = 3'($urandom);
         end
         any_btn = bus.left | bus.right | bus.put;
         if ((int'(bus.left) + int'(bus.right) + int'(bus.put)) > 1) overlap++;
         if (bus.right && !r_prev) begin
            n_right++;
            if (bus.cur_col == 3'd6) range_viol++;
         end
         if (bus.left && !l_prev) begin
            n_left++;
            if (bus.cur_col == 3'd0) range_viol++;
         end
         if (bus.put && !p_prev) begin
            n_put++;
            if (put_k < 0) put_k = k;
         end
         if (any_btn && !any_prev) begin
            if (seen_pulse && low_run < GAP_LEN) gap_viol++;
            seen_pulse = 1;
            width      = 0;
         end
         if (any_btn) width++;
         if (!any_btn && any_prev && width != PULSE_LEN) width_viol++;
         low_run = any_btn ? 0 : low_run + 1;
         if (bus.move_done) begin n_done++;   done_k   = k; end
         if (bus.no_move)   begin n_nomove++; nomove_k = k; end
         if (bus.error)     begin n_err++;    err_k    = k; end
         if (bus.busy !== 1'b1) busy_drop++;
         any_prev = any_btn; r_prev = bus.right; l_prev = bus.left; p_prev = bus.put;
      end

      bus.my_turn = 1'b0;
      @(negedge clk);
      check("busy_after_turn", bus.busy, 0);

      if (!any) begin
         check("no_move_count", n_nomove, 1);
         check("no_move_cycle", nomove_k, 2);
         check("buttons_on_no_move", n_right + n_left + n_put, 0);
         check("move_done_on_no_move", n_done, 0);
         check("error_on_no_move", n_err, 0);
      end else if (resp || n == 0) begin
         check("right_pulses", n_right, (tgt > c0i) ? n : 0);
         check("left_pulses", n_left, (tgt < c0i) ? n : 0);
         check("put_pulses", n_put, 1);
         check("put_rise_cycle", put_k, 2 + n * (PULSE_LEN + GAP_LEN + 1));
         check("move_done_count", n_done, 1);
         check("move_done_cycle", done_k, 2 + n * (PULSE_LEN + GAP_LEN + 1));
         check("error_count", n_err, 0);
         check("no_move_count", n_nomove, 0);
         check("final_col", bus.cur_col, tgt);
      end else begin
         check("stuck_right_pulses", n_right, (tgt > c0i) ? 1 : 0);
         check("stuck_left_pulses", n_left, (tgt < c0i) ? 1 : 0);
         check("stuck_put_pulses", n_put, 0);
         check("stuck_move_done", n_done, 0);
         check("stuck_error_count", n_err, 1);
         check("stuck_error_cycle", err_k, 2 + PULSE_LEN + GAP_LEN + ACK_TIMEOUT);
      end
      check("button_overlap", overlap, 0);
      check("pulse_width", width_viol, 0);
      check("pulse_gap", gap_viol, 0);
      check("step_out_of_range", range_viol, 0);
      check("busy_during_turn", busy_drop, 0);
      @(negedge clk);
   endtask

   initial begin
      logic [41:0] occ;
      int          quiet;

      rst              = 1'b1;
      bus.my_turn      = 1'b0;
      bus.occupied     = '0;
      bus.target_valid = 1'b0;
      bus.target_col   = 3'd0;
      col_load         = 1'b1;
      col_load_val     = 3'd0;
      repeat (3) @(negedge clk);
      check("reset_left", bus.left, 0);
      check("reset_right", bus.right, 0);
      check("reset_put", bus.put, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_move_done", bus.move_done, 0);
      check("reset_no_move", bus.no_move, 0);
      check("reset_error", bus.error, 0);
      rst      = 1'b0;
      col_load = 1'b0;
      @(negedge clk);

      // Empty board, already on column 0: immediate put.
      run_turn(42'd0, 1'b0, 3'd0, 3'd0, 1'b1);
      // Requested column 5 from column 2: three right steps.
      run_turn(42'd0, 1'b1, 3'd5, 3'd2, 1'b1);
      // Column 4 and column 0 full: falls back to column 1 from column 3.
      occ = col_full(4) | col_full(0);
      run_turn(occ, 1'b1, 3'd4, 3'd3, 1'b1);
      // Every top cell occupied: no legal move.
      run_turn({7'h7F, 35'd0}, 1'b1, 3'd2, 3'd4, 1'b1);
      // Player FSM ignores buttons: step never acknowledged.
      run_turn(42'd0, 1'b1, 3'd3, 3'd0, 1'b0);
      // Out-of-range request with column 0 full: lowest legal is column 1.
      run_turn(col_full(0), 1'b1, 3'd7, 3'd6, 1'b1);

      // my_turn drops during the second right pulse.
      turn_id++;
      bus.occupied     = '0;
      bus.target_valid = 1'b1;
      bus.target_col   = 3'd5;
      col_load_val     = 3'd2;
      col_load         = 1'b1;
      fsm_resp         = 1'b1;
      @(negedge clk);
      col_load    = 1'b0;
      bus.my_turn = 1'b1;
      repeat (2 + PULSE_LEN + GAP_LEN + 1) @(negedge clk);
      check("abort_second_right_high", bus.right, 1);
      bus.my_turn = 1'b0;
      @(negedge clk);
      check("abort_right_low", bus.right, 0);
      check("abort_busy_low", bus.busy, 0);
      check("abort_no_move_done", bus.move_done, 0);
      quiet = 0;
      repeat (10) begin
         @(negedge clk);
         quiet += int'(bus.left | bus.right | bus.put | bus.move_done | bus.error | bus.busy);
      end
      check("abort_stays_quiet", quiet, 0);

      // Same case with rst asserted mid-pulse.
      turn_id++;
      col_load_val = 3'd2;
      col_load     = 1'b1;
      @(negedge clk);
      col_load    = 1'b0;
      bus.my_turn = 1'b1;
      repeat (2 + PULSE_LEN + GAP_LEN + 1) @(negedge clk);
      check("rst_case_second_right_high", bus.right, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_outputs_cleared",
            {bus.left, bus.right, bus.put, bus.busy, bus.move_done, bus.no_move, bus.error}, 0);
      rst         = 1'b0;
      bus.my_turn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_case_idle", bus.busy, 0);

      // Randomized turns checked against the reference model.
      for (int t = 0; t < 24; t++) begin
         occ = {10'($urandom), $urandom};
         for (int c = 0; c < 7; c++) occ[35 + c] = ($urandom_range(0, 9) < 4);
         if (t % 8 == 7) occ[41:35] = 7'h7F;
         run_turn(occ, 1'($urandom), 3'($urandom), 3'($urandom_range(0, 6)),
                  ($urandom_range(0, 4) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish before 1000000");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/c4_move_driver.md
# c4_move_driver

Automated Connect-Four opponent front end: drives the `left`/`right`/`put` button inputs of a player FSM, replacing a human player. When the player FSM reports its turn, the block picks a legal column from the board occupancy. It then steps the FSM's selected column to that target with clean pulses that the FSM's rising-edge detectors will see, and issues `put`. It sits between the board/turn signals and one player FSM's button inputs, in place of the debounced push-buttons.

## Interface
- `PULSE_LEN`, default 2: cycles each button pulse is held high (≥1).
- `GAP_LEN`, default 2: minimum low cycles after each pulse (≥1).
- `ACK_TIMEOUT`, default 16: cycles to wait for `cur_col` to reflect a step before aborting.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `my_turn` in 1: high while the driven player FSM accepts moves.
- `cur_col` in 3: selected column currently reported by the player FSM (0..6).
- `occupied` in 42: `color_p0 | color_p1`; bit 7*row+col, row 0 = bottom, top row = bits 35..41.
- `target_valid` in 1: requested column supplied.
- `target_col` in 3: requested column; sampled in CHOOSE.
- `left`, `right`, `put` out 1: button pulses to the player FSM.
- `busy` out 1: high in every state except IDLE.
- `move_done` out 1: one-cycle pulse on the cycle `put` rises.
- `no_move` out 1: one-cycle pulse when no column is legal.
- `error` out 1: one-cycle pulse on ACK_TIMEOUT expiry.

## Operation
- All outputs registered. Reset values: `left`/`right`/`put`/`move_done`/`no_move`/`error` = 0, `busy` = 0, state = IDLE, target register = 0, counters = 0.
- States and transitions:
  - IDLE → CHOOSE when `my_turn` = 1.
  - CHOOSE (1 cycle): legal(c) = c ≤ 6 and `occupied[35+c]` = 0.
    - If `target_valid` and legal(`target_col`), tgt = `target_col`.
    - Else tgt = lowest c with legal(c).
    - If no c is legal: pulse `no_move`, go to DONE_WAIT.
    - Else go to STEP if `cur_col` ≠ tgt, PUT if `cur_col` = tgt.
  - STEP: hold `right` (tgt > `cur_col`) or `left` (tgt < `cur_col`) high for PULSE_LEN cycles, then low for GAP_LEN cycles, then go to WAIT_COL.
  - WAIT_COL: compare `cur_col` with the value latched at STEP entry.
    - If changed: go to PUT if `cur_col` = tgt, else back to STEP.
    - If unchanged after ACK_TIMEOUT cycles: pulse `error`, go to DONE_WAIT.
  - PUT: `put` high for PULSE_LEN cycles; `move_done` on the first of them. Then GAP_LEN low cycles, then DONE_WAIT.
  - DONE_WAIT: all pulses low; → IDLE when `my_turn` = 0.
- Never drive two of `left`/`right`/`put` high in the same cycle.
- Only one step per pulse; never step past column 0 or 6. This prevents the FSM's out-of-range invalid-move path from triggering.
- `my_turn` falling in any state other than IDLE/DONE_WAIT aborts:
  - next cycle all pulses low, state = IDLE;
  - no `move_done`/`error`;
  - an in-flight pulse is truncated.
- `target_valid` with `target_col` = 7, or a full target column, falls back to the lowest legal column without error.
- `occupied`/`target_*` changes after CHOOSE are ignored until the next turn.
- `rst` mid-operation: outputs return to reset values on the next edge.

## Timing
- Latency `my_turn` rise → first pulse edge: 2 cycles (IDLE→CHOOSE, CHOOSE→STEP/PUT registered).
- Per step: PULSE_LEN + GAP_LEN cycles plus WAIT_COL cycles. WAIT_COL is ≥1 cycle, since `cur_col` updates one cycle after the FSM sees the edge.
- Defaults, `cur_col` = 0, tgt = 3: 3 steps × (2+2+1) + put (2+2) + 2 = 21 cycles to DONE_WAIT.
- Button low time between any two pulses ≥ GAP_LEN. This guarantees a fresh rising edge for a registered edge detector.
- Timeout counter width: $clog2(ACK_TIMEOUT+1). Pulse and gap counters are sized likewise and saturate, never wrap.

## Test plan
- Empty board, `cur_col` = 0, `target_valid` = 0, `my_turn` rises:
  - no steps;
  - `put` high for cycles 2–3;
  - `move_done` at cycle 2;
  - after `my_turn` falls, `busy` → 0.
- `target_col` = 5, `cur_col` = 2, model FSM increments `cur_col` 1 cycle after each `right` edge:
  - exactly 3 `right` pulses of 2 cycles, each followed by ≥2 low cycles;
  - no `left`;
  - then 1 `put`.
- `target_col` = 4 with `occupied[39]` = 1 (column 4 full), column 0 full, `cur_col` = 3:
  - tgt = 1;
  - 2 `left` pulses, then `put`.
- All top bits 35..41 set: `no_move` pulses once 1 cycle after CHOOSE; no button pulses.
- Model FSM ignores buttons (`cur_col` stuck at 0), tgt = 3:
  - one `right` pulse;
  - `error` exactly ACK_TIMEOUT cycles into WAIT_COL;
  - no `put`.
- `my_turn` drops during the second `right` pulse: `right` low next cycle, state IDLE, no `move_done`. Repeat the same case with `rst` asserted mid-pulse: all outputs 0 the next cycle.
